// File: rtl/pomdp_episode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pomdp_episode_ctrl
//  Purpose  : POMDP episode sequencer. Runs a bounded episode of num_steps
//             steps, each step being decide -> environment step -> belief
//             update, through req/done handshakes with external engines.
//             Owns current hidden state, belief, step count and a saturating
//             signed reward accumulator.
//  Ports    : clk, rst_n (async, active low)
//             start, abort, num_steps, initial_state, initial_belief : control
//             dec_req/dec_done/dec_action                    : decision engine
//             env_req/env_done/env_state/env_obs/env_reward  : environment
//             bel_req/bel_done/bel_belief                    : belief engine
//             action, observation, cur_state, belief, reward, step_cnt,
//             busy, done                                     : status
//  Options  : POMDP_DISCOUNT_EN adds input gamma (unsigned Q0.W) and a
//             geometric discount applied to every step reward.
//  Revision : 1.0  initial release
// ============================================================================
module pomdp_episode_ctrl #(
  parameter int N_STATE = 2,
  parameter int N_ACT   = 3,
  parameter int N_OBS   = 2,
  parameter int W       = 16,
  parameter int RW      = 32,
  parameter int STEP_W  = 16,
  localparam int SW     = $clog2(N_STATE),
  localparam int AW     = $clog2(N_ACT),
  localparam int OW     = $clog2(N_OBS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic [SW-1:0]        initial_state,
  input  logic [N_STATE*W-1:0] initial_belief,
`ifdef POMDP_DISCOUNT_EN
  input  logic [W-1:0]         gamma,
`endif
  output logic                 dec_req,
  input  logic                 dec_done,
  input  logic [AW-1:0]        dec_action,
  output logic                 env_req,
  input  logic                 env_done,
  input  logic [SW-1:0]        env_state,
  input  logic [OW-1:0]        env_obs,
  input  logic [W-1:0]         env_reward,
  output logic                 bel_req,
  input  logic                 bel_done,
  input  logic [N_STATE*W-1:0] bel_belief,
  output logic [AW-1:0]        action,
  output logic [OW-1:0]        observation,
  output logic [SW-1:0]        cur_state,
  output logic [N_STATE*W-1:0] belief,
  output logic [RW-1:0]        reward,
  output logic [STEP_W-1:0]    step_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECIDE = 3'd1;
  localparam logic [2:0] S_ENV    = 3'd2;
  localparam logic [2:0] S_BELIEF = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state, next_state;
  logic [STEP_W-1:0] steps_lat;
  logic [SW-1:0]     staged_state;
  logic [STEP_W-1:0] step_inc;

  // Per-cycle events decoded by the output process
  logic start_go, dec_ev, env_ev, bel_ev;
  logic dec_req_d, env_req_d, bel_req_d, done_d;

  // Reward path: W+1-bit signed addend, RW+1-bit sum for overflow detection
  logic signed [W:0]  reward_add;
  logic        [RW:0] acc_sum;
  logic [RW-1:0]      reward_sat;

  assign step_inc = step_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A done only counts while its own req is high, and
  // abort wins over any handshake completing in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && !abort)
          next_state = (num_steps == '0) ? S_DONE : S_DECIDE;
      end
      S_DECIDE: begin
        if (abort)                    next_state = S_DONE;
        else if (dec_req && dec_done) next_state = S_ENV;
      end
      S_ENV: begin
        if (abort)                    next_state = S_DONE;
        else if (env_req && env_done) next_state = S_BELIEF;
      end
      S_BELIEF: begin
        if (abort)                    next_state = S_DONE;
        else if (bel_req && bel_done)
          next_state = (step_inc == steps_lat) ? S_DONE : S_DECIDE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / event logic. A req is registered high only while the FSM stays
  // in its phase, so it rises one cycle after entry and falls right after
  // its done (or an abort). done pulses on every entry into DONE, including
  // a zero-length restart issued from DONE itself.
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state == S_DECIDE) || (state == S_ENV) || (state == S_BELIEF);
    start_go  = ((state == S_IDLE) || (state == S_DONE)) && start && !abort;
    dec_ev    = (state == S_DECIDE) && dec_req && dec_done && !abort;
    env_ev    = (state == S_ENV)    && env_req && env_done && !abort;
    bel_ev    = (state == S_BELIEF) && bel_req && bel_done && !abort;
    dec_req_d = (state == S_DECIDE) && (next_state == S_DECIDE);
    env_req_d = (state == S_ENV)    && (next_state == S_ENV);
    bel_req_d = (state == S_BELIEF) && (next_state == S_BELIEF);
    done_d    = (next_state == S_DONE) && ((state != S_DONE) || start_go);
  end

  // --------------------------------------------------------------------------
  // Reward addend: plain sign extension, or the discounted product.
  // --------------------------------------------------------------------------
`ifdef POMDP_DISCOUNT_EN
  logic [W-1:0]         gpow;
  logic signed [2*W:0]  disc_prod;
  logic [2*W-1:0]       gpow_prod;
  logic                 unused_disc_lsbs;

  // gpow is unsigned, so a zero MSB makes it a non-negative signed operand
  assign disc_prod        = $signed(env_reward) * $signed({1'b0, gpow});
  assign reward_add       = disc_prod[2*W:W];
  assign gpow_prod        = gpow * gamma;
  assign unused_disc_lsbs = ^{disc_prod[W-1:0], gpow_prod[W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        gpow <= '0;
    else if (start_go) gpow <= '1;
    else if (env_ev)   gpow <= gpow_prod[2*W-1:W];
  end
`else
  assign reward_add = {env_reward[W-1], env_reward};
`endif

  assign acc_sum = {reward[RW-1], reward} + {{(RW-W){reward_add[W]}}, reward_add};

  // Top two sum bits disagree only on signed overflow; clamp toward its sign
  always_comb begin
    if (acc_sum[RW] != acc_sum[RW-1])
      reward_sat = acc_sum[RW] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
    else
      reward_sat = acc_sum[RW-1:0];
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_req      <= 1'b0;
      env_req      <= 1'b0;
      bel_req      <= 1'b0;
      done         <= 1'b0;
      action       <= '0;
      observation  <= '0;
      cur_state    <= '0;
      staged_state <= '0;
      belief       <= '0;
      reward       <= '0;
      step_cnt     <= '0;
      steps_lat    <= '0;
    end else begin
      dec_req <= dec_req_d;
      env_req <= env_req_d;
      bel_req <= bel_req_d;
      done    <= done_d;
      if (start_go) begin
        steps_lat <= num_steps;
        cur_state <= initial_state;
        belief    <= initial_belief;
        reward    <= '0;
        step_cnt  <= '0;
      end
      if (dec_ev) action <= dec_action;
      if (env_ev) begin
        observation  <= env_obs;
        staged_state <= env_state;
        reward       <= reward_sat;
      end
      // cur_state moves only here so the belief engine sees the old state
      if (bel_ev) begin
        belief    <= bel_belief;
        cur_state <= staged_state;
        step_cnt  <= step_inc;
      end
    end
  end

endmodule
`default_nettype wire
